// File: rtl/md_unit_seq_pkg.sv
// Shared opcode encodings, FSM state type and op decode for the multiply/divide unit.
package md_unit_seq_pkg;

  localparam int WIDTH_MDOP = 4;

  localparam logic [WIDTH_MDOP-1:0] MD_NOP   = 4'd0;
  localparam logic [WIDTH_MDOP-1:0] MD_MULT  = 4'd1;
  localparam logic [WIDTH_MDOP-1:0] MD_MULTU = 4'd2;
  localparam logic [WIDTH_MDOP-1:0] MD_MADD  = 4'd3;
  localparam logic [WIDTH_MDOP-1:0] MD_MADDU = 4'd4;
  localparam logic [WIDTH_MDOP-1:0] MD_MSUB  = 4'd5;
  localparam logic [WIDTH_MDOP-1:0] MD_MSUBU = 4'd6;
  localparam logic [WIDTH_MDOP-1:0] MD_DIV   = 4'd7;
  localparam logic [WIDTH_MDOP-1:0] MD_DIVU  = 4'd8;
  localparam logic [WIDTH_MDOP-1:0] MD_MTHI  = 4'd9;
  localparam logic [WIDTH_MDOP-1:0] MD_MTLO  = 4'd10;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} md_state_e;
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} md_acc_e;
  typedef enum logic [1:0] {CLS_NONE, CLS_MUL, CLS_DIV, CLS_MOVE} md_cls_e;

  typedef struct packed {
    md_cls_e cls;
    md_acc_e acc;
    logic    sgn;
  } md_dec_t;

  function automatic md_dec_t md_decode(input logic [WIDTH_MDOP-1:0] op);
    md_dec_t d;
    d = '{cls: CLS_NONE, acc: ACC_SET, sgn: 1'b0};
    case (op)
      MD_MULT:          d = '{cls: CLS_MUL, acc: ACC_SET, sgn: 1'b1};
      MD_MULTU:         d = '{cls: CLS_MUL, acc: ACC_SET, sgn: 1'b0};
      MD_MADD:          d = '{cls: CLS_MUL, acc: ACC_ADD, sgn: 1'b1};
      MD_MADDU:         d = '{cls: CLS_MUL, acc: ACC_ADD, sgn: 1'b0};
      MD_MSUB:          d = '{cls: CLS_MUL, acc: ACC_SUB, sgn: 1'b1};
      MD_MSUBU:         d = '{cls: CLS_MUL, acc: ACC_SUB, sgn: 1'b0};
      MD_DIV:           d = '{cls: CLS_DIV, acc: ACC_SET, sgn: 1'b1};
      MD_DIVU:          d = '{cls: CLS_DIV, acc: ACC_SET, sgn: 1'b0};
      MD_MTHI, MD_MTLO: d.cls = CLS_MOVE;
      default:          ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, with a
// combinational sign fix-up on the held result.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             kill,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_run, r_valid, r_neg_q, r_neg_r;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_bit;

  assign w_a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  // r_quo starts as the dividend and shifts quotient bits in from the right.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_bit   = !w_trial[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_valid <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (kill) begin
      r_run   <= 1'b0;
      r_valid <= 1'b0;
    end else if (go) begin
      r_rem   <= '0;
      r_quo   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_cnt   <= CW'(WIDTH);
      r_run   <= 1'b1;
      r_valid <= 1'b0;
      r_neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= sgn && a[WIDTH-1];
    end else if (r_run) begin
      r_rem <= w_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_bit};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_run   <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

  // Divide-by-zero falls out naturally: quotient all-ones, remainder = |a|.
  assign quo   = r_neg_q ? -r_quo : r_quo;
  assign rem   = r_neg_r ? -r_rem : r_rem;
  assign valid = r_valid;

endmodule

// File: rtl/md_unit_seq.sv
// Multi-cycle multiply/divide unit with HI/LO; results commit atomically so a
// cancelled op leaves HI/LO untouched.
module md_unit_seq
  import md_unit_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH_MDOP-1:0] op,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      hi,
  output logic [WIDTH-1:0]      lo,
  output md_state_e             o_dbg_state
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  if (MUL_LAT < 1) begin : g_mul_lat_chk
    $error("md_unit_seq: MUL_LAT must be >= 1");
  end
  if (DIV_LAT < WIDTH + 1) begin : g_div_lat_chk
    $error("md_unit_seq: DIV_LAT must be >= WIDTH+1");
  end

  md_state_e          r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy, r_done, r_sgn;
  md_acc_e            r_acc;
  logic [WIDTH-1:0]   r_hi, r_lo, r_a, r_b;
  md_dec_t            w_dec;
  logic               w_accept, w_commit, w_div_go, w_div_kill, w_cnt_zero;
  logic               w_acc_mul, w_acc_div, w_div_valid;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_hilo, w_result;

  // Handshake: an op is taken on any edge where start=1, busy=0, cancel=0 and the
  // opcode is known; nothing is queued, the requester must hold off while busy=1.
  assign w_dec      = md_decode(op);
  assign w_accept   = start && !r_busy && !cancel && (w_dec.cls != CLS_NONE);
  assign w_acc_mul  = w_accept && (w_dec.cls == CLS_MUL);
  assign w_acc_div  = w_accept && (w_dec.cls == CLS_DIV);
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc_mul)      w_next_state = ST_MUL;
        else if (w_acc_div) w_next_state = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cancel || w_cnt_zero) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_commit   = 1'b0;
    w_div_go   = 1'b0;
    w_div_kill = 1'b0;
    case (r_state)
      ST_IDLE: w_div_go = w_acc_div;
      ST_MUL:  w_commit = !cancel && w_cnt_zero;
      ST_DIV: begin
        w_commit   = !cancel && w_cnt_zero && w_div_valid;
        w_div_kill = cancel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                      r_cnt <= '0;
    else if (w_acc_mul)             r_cnt <= MUL_LOAD;
    else if (w_acc_div)             r_cnt <= DIV_LOAD;
    else if (w_next_state == ST_IDLE) r_cnt <= '0;
    else                            r_cnt <= r_cnt - CNT_W'(1);
  end

  assign w_a_ext = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_b_ext = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_hilo  = {r_hi, r_lo};

  // MADD/MSUB accumulate onto HI/LO as they stand at commit time.
  always_comb begin
    w_result = w_prod;
    if (r_state == ST_DIV) begin
      w_result = {w_rem, w_quo};
    end else begin
      case (r_acc)
        ACC_ADD: w_result = w_hilo + w_prod;
        ACC_SUB: w_result = w_hilo - w_prod;
        default: w_result = w_prod;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sgn  <= 1'b0;
      r_acc  <= ACC_SET;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_a   <= src_a;
        r_b   <= src_b;
        r_sgn <= w_dec.sgn;
        r_acc <= w_dec.acc;
      end
      if (w_accept && op == MD_MTHI) r_hi <= src_a;
      if (w_accept && op == MD_MTLO) r_lo <= src_a;
      if (w_commit) {r_hi, r_lo} <= w_result;
    end
  end

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .go    (w_div_go),
    .kill  (w_div_kill),
    .sgn   (w_dec.sgn),
    .a     (src_a),
    .b     (src_b),
    .quo   (w_quo),
    .rem   (w_rem),
    .valid (w_div_valid)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md_unit_seq.sv
// Directed bench for md_unit_seq: vector table for the main ops plus hand-written
// sequences for cancel, reset, start-while-busy and single-cycle moves.
module tb_md_unit_seq;
  import md_unit_seq_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = W + 1;
  localparam int NVEC    = 17;

  logic                  clk = 1'b0;
  logic                  reset, start, cancel;
  logic [WIDTH_MDOP-1:0] op;
  logic [W-1:0]          src_a, src_b;
  logic                  busy, done;
  logic [W-1:0]          hi, lo;
  md_state_e             dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs [NVEC];

  md_unit_seq #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    src_a  = a;
    src_b  = b;
    cancel = c;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = MD_NOP;
    cancel = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int dones);
    issue(o, a, b, 1'b0);
    cyc   = 0;
    dones = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    if (done) dones++;
    @(posedge clk);
    #1;
    if (done) dones++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dones;
    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h6,        32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[2]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h6,        32'h00000000, 32'h00000001, MUL_LAT};
    vecs[3]  = '{MD_MADDU, 32'hFFFFFFFF, 32'd2,        32'h1, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, MUL_LAT};
    vecs[4]  = '{MD_MADD,  32'hFFFFFFFE, 32'd3,        32'h0, 32'd10,       32'h00000000, 32'h00000004, MUL_LAT};
    vecs[5]  = '{MD_MSUB,  32'd2,        32'd3,        32'h0, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
    vecs[6]  = '{MD_MSUBU, 32'hFFFFFFFF, 32'd1,        32'h0, 32'h0,        32'hFFFFFFFF, 32'h00000001, MUL_LAT};
    vecs[7]  = '{MD_MSUB,  32'hFFFFFFFF, 32'd1,        32'h0, 32'h0,        32'h00000000, 32'h00000001, MUL_LAT};
    vecs[8]  = '{MD_MADD,  32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,         MUL_LAT};
    vecs[9]  = '{MD_DIVU,  32'd100,      32'd7,        32'h7, 32'h7,        32'd2,        32'd14,        DIV_LAT};
    vecs[10] = '{MD_DIV,   32'hFFFFFF9C, 32'd7,        32'h7, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFF2, DIV_LAT};
    vecs[11] = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'h7, 32'h7,        32'hFFFFFFFB, 32'h00000001, DIV_LAT};
    vecs[12] = '{MD_DIVU,  32'd5,        32'd0,        32'h7, 32'h7,        32'h00000005, 32'hFFFFFFFF, DIV_LAT};
    vecs[13] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h7, 32'h7,        32'h00000000, 32'h80000000, DIV_LAT};
    vecs[14] = '{MD_DIV,   32'd100,      32'hFFFFFFF9, 32'h7, 32'h7,        32'h00000002, 32'hFFFFFFF2, DIV_LAT};
    vecs[15] = '{MD_DIVU,  32'hFFFFFFFF, 32'd10,       32'h7, 32'h7,        32'h00000005, 32'h19999999, DIV_LAT};
    vecs[16] = '{MD_DIV,   32'd5,        32'd0,        32'h7, 32'h7,        32'h00000005, 32'hFFFFFFFF, DIV_LAT};

    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = MD_NOP; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      issue(MD_MTHI, vecs[i].pre_hi, 32'h0, 1'b0);
      issue(MD_MTLO, vecs[i].pre_lo, 32'h0, 1'b0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, dones);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      chk($sformatf("vec%0d_done_pulses", i), 64'(dones), 64'd1);
    end

    // MTHI/MTLO are single-cycle and never raise busy or done
    issue(MD_MTHI, 32'hDEAD0001, 32'h0, 1'b0);
    chk("mthi_hi", 64'(hi), 64'hDEAD0001);
    chk("mthi_busy", 64'(busy), 64'h0);
    chk("mthi_done", 64'(done), 64'h0);
    issue(MD_MTLO, 32'hBEEF0002, 32'h0, 1'b0);
    chk("mtlo_lo", 64'(lo), 64'hBEEF0002);
    chk("mtlo_hi_kept", 64'(hi), 64'hDEAD0001);

    // cancel together with start blocks the accept
    issue(MD_MTHI, 32'h12345678, 32'h0, 1'b1);
    chk("cancel_start_mthi_hi", 64'(hi), 64'hDEAD0001);
    issue(MD_MULT, 32'd2, 32'd3, 1'b1);
    chk("cancel_start_mult_busy", 64'(busy), 64'h0);
    chk("cancel_start_mult_state", 64'(dbg_state), 64'(ST_IDLE));

    // NOP and unknown opcodes are ignored
    issue(MD_NOP, 32'h1, 32'h1, 1'b0);
    chk("nop_busy", 64'(busy), 64'h0);
    issue(4'hF, 32'h1, 32'h1, 1'b0);
    chk("unknown_busy", 64'(busy), 64'h0);
    chk("unknown_hilo", {32'(hi), 32'(lo)}, 64'hDEAD0001_BEEF0002);

    // DIV cancelled in its 10th busy cycle
    issue(MD_MTHI, 32'hAAAA5555, 32'h0, 1'b0);
    issue(MD_MTLO, 32'h5555AAAA, 32'h0, 1'b0);
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    chk("div_cancel_state", 64'(dbg_state), 64'(ST_DIV));
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("div_cancel_busy_before", 64'(busy), 64'h1);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("div_cancel_busy_after", 64'(busy), 64'h0);
    chk("div_cancel_state_after", 64'(dbg_state), 64'(ST_IDLE));
    dones = 0;
    repeat (40) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    chk("div_cancel_done_pulses", 64'(dones), 64'h0);
    chk("div_cancel_hilo", {32'(hi), 32'(lo)}, 64'hAAAA5555_5555AAAA);

    // cancel on the commit cycle wins over the commit
    issue(MD_MULT, 32'd2, 32'd3, 1'b0);
    repeat (MUL_LAT - 1) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("commit_cancel_busy", 64'(busy), 64'h0);
    chk("commit_cancel_done", 64'(done), 64'h0);
    chk("commit_cancel_hilo", {32'(hi), 32'(lo)}, 64'hAAAA5555_5555AAAA);
    @(posedge clk);
    #1;
    chk("commit_cancel_done_late", 64'(done), 64'h0);

    // start while busy is ignored and nothing is queued
    issue(MD_MTHI, 32'h99, 32'h0, 1'b0);
    issue(MD_MULT, 32'd4, 32'd5, 1'b0);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      start = (cyc <= 4);
      op    = (cyc % 2 == 1) ? MD_MTHI : MD_MULT;
      src_a = 32'h1234;
      src_b = 32'd7;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    op    = MD_NOP;
    chk("busy_start_cycles", 64'(cyc), 64'(MUL_LAT));
    chk("busy_start_hilo", {32'(hi), 32'(lo)}, 64'h00000000_00000014);
    @(posedge clk);
    #1;
    chk("busy_start_no_queue", 64'(busy), 64'h0);

    // reset in the 3rd busy cycle of a MULT
    issue(MD_MTHI, 32'h1111, 32'h0, 1'b0);
    issue(MD_MTLO, 32'h2222, 32'h0, 1'b0);
    issue(MD_MULT, 32'd3, 32'd3, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_hi", 64'(hi), 64'h0);
    chk("midreset_lo", 64'(lo), 64'h0);
    chk("midreset_busy", 64'(busy), 64'h0);
    chk("midreset_done", 64'(done), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("midreset_after_done", 64'(dones), 64'h0);
    chk("midreset_after_hilo", {32'(hi), 32'(lo)}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
